// File: rtl/conv_window_gen.sv
// Sliding 5x5 window generator: raster pixel stream in, 25 parallel bytes out.
// Four column-stacked line buffers feed the top four window rows; pix_in feeds the bottom row.
module conv_window_gen #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int CW    = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          pix_valid,
    input  logic [7:0]    pix_in,
    output logic          win_valid,
    output logic [199:0]  win_out,
    output logic [CW-1:0] win_row,
    output logic [CW-1:0] win_col,
    output logic          frame_done
);

    localparam int AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);
    localparam logic [CW-1:0] EDGE     = CW'(4);

    logic [CW-1:0] row_q, row_d, col_q, col_d;
    logic [CW-1:0] cur_row, cur_col;
    logic [AW-1:0] rd_addr;
    logic          win_fire, last_pix;

    // lb_q[k][x] holds pixel(row-4+k, x) for the column about to be written
    logic [7:0]    lb_q  [4][IMG_W];
    logic [7:0]    win_q [5][5];
    logic [7:0]    win_d [5][5];
    logic [199:0]  win_pack_d;

    logic          valid_q, done_q;
    logic [199:0]  out_q;
    logic [CW-1:0] wrow_q, wcol_q;

    always_comb begin
        cur_row = start ? '0 : row_q;
        cur_col = start ? '0 : col_q;
        rd_addr = cur_col[AW-1:0];
        row_d   = cur_row;
        col_d   = cur_col;
        if (pix_valid) begin
            if (cur_col == LAST_COL) begin
                col_d = '0;
                row_d = (cur_row == LAST_ROW) ? '0 : cur_row + CW'(1);
            end else begin
                col_d = cur_col + CW'(1);
            end
        end
        win_fire = pix_valid && (cur_row >= EDGE) && (cur_col >= EDGE);
        last_pix = (cur_row == LAST_ROW) && (cur_col == LAST_COL);
    end

    always_comb begin
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                win_d[r][c] = win_q[r][c];
            end
        end
        if (pix_valid) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
            end
            for (int r = 0; r < 4; r++) begin
                win_d[r][4] = lb_q[r][rd_addr];
            end
            win_d[4][4] = pix_in;
        end
    end

    always_comb begin
        win_pack_d = '0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                win_pack_d[8*(5*r+c) +: 8] = win_d[r][c];
            end
        end
    end

    // Storage is never exposed before being rewritten, so it carries no reset.
    always_ff @(posedge clk) begin
        if (!rst && pix_valid) begin
            for (int k = 0; k < 3; k++) begin
                lb_q[k][rd_addr] <= lb_q[k+1][rd_addr];
            end
            lb_q[3][rd_addr] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            win_q <= win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            wrow_q  <= '0;
            wcol_q  <= '0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            valid_q <= win_fire;
            done_q  <= win_fire && last_pix;
            if (win_fire) begin
                out_q  <= win_pack_d;
                wrow_q <= cur_row - EDGE;
                wcol_q <= cur_col - EDGE;
            end
        end
    end

    assign win_valid  = valid_q;
    assign frame_done = done_q;
    assign win_out    = out_q;
    assign win_row    = wrow_q;
    assign win_col    = wcol_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: a frame-image model pushes expected windows,
// a negedge monitor pops and compares them against whatever the DUT emits.
module tb_conv_window_gen;

    localparam int W  = 32;
    localparam int H  = 32;
    localparam int CW = 6;

    logic           clk = 1'b0;
    logic           rst, start, pix_valid;
    logic [7:0]     pix_in;
    logic           win_valid, frame_done;
    logic [199:0]   win_out;
    logic [CW-1:0]  win_row, win_col;

    conv_window_gen #(.IMG_W(W), .IMG_H(H), .CW(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_valid  (pix_valid),
        .pix_in     (pix_in),
        .win_valid  (win_valid),
        .win_out    (win_out),
        .win_row    (win_row),
        .win_col    (win_col),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [199:0]  win;
        logic [CW-1:0] row;
        logic [CW-1:0] col;
        logic          done;
    } exp_t;

    exp_t       expq[$];
    logic [7:0] img [H][W];
    int         mr, mc;
    int         checks = 0;
    int         failures = 0;
    int         n_win = 0;
    int         n_done = 0;
    bit         acc_edge = 1'b0;
    bit         mon_en = 1'b0;
    bit         chk_zero, chk_nowin;

    task automatic check_zero(input string tag);
        checks++;
        if (win_valid !== 1'b0 || frame_done !== 1'b0 || win_out !== '0 ||
            win_row !== '0 || win_col !== '0) begin
            failures++;
            $display("FAIL %s: valid=%0b done=%0b row=%0d col=%0d out=%h, required all zero",
                     tag, win_valid, frame_done, win_row, win_col, win_out);
        end
    endtask

    // Applies one cycle of inputs, updates the model, and returns just after the edge.
    task automatic drive(input logic [7:0] p, input bit v, input bit st);
        exp_t e;
        if (chk_zero) begin
            check_zero("post_reset");
            chk_zero = 1'b0;
        end
        if (chk_nowin) begin
            checks++;
            if (win_valid !== 1'b0) begin
                failures++;
                $display("FAIL after_start: win_valid=%0b, required 0", win_valid);
            end
            chk_nowin = 1'b0;
        end
        rst = 1'b0; start = st; pix_valid = v; pix_in = p;
        if (st) begin
            mr = 0; mc = 0;
        end
        if (v) begin
            img[mr][mc] = p;
            if (mr >= 4 && mc >= 4) begin
                e.win = '0;
                for (int rr = 0; rr < 5; rr++)
                    for (int cc = 0; cc < 5; cc++)
                        e.win[8*(5*rr+cc) +: 8] = img[mr-4+rr][mc-4+cc];
                e.row  = CW'(mr - 4);
                e.col  = CW'(mc - 4);
                e.done = (mr == H-1) && (mc == W-1);
                expq.push_back(e);
            end
            mc++;
            if (mc == W) begin
                mc = 0;
                mr++;
                if (mr == H) mr = 0;
            end
        end
        chk_nowin = st;
        @(posedge clk); #1;
    endtask

    // mode 0: ramp continuous, 1: ramp with random stalls, 2: random pixels
    task automatic send_frame(input int mode, input int off, input int stop_r,
                              input int stop_c, input bit st_first);
        logic [7:0] p;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (r == stop_r && c == stop_c) return;
                if (mode == 1)
                    while ($urandom_range(0, 1) == 1) drive(8'($urandom), 1'b0, 1'b0);
                p = (mode == 2) ? 8'($urandom) : 8'((32*r + c + off) % 256);
                drive(p, 1'b1, st_first && r == 0 && c == 0);
            end
        end
    endtask

    always @(posedge clk) acc_edge = (pix_valid === 1'b1) && (rst === 1'b0);

    always @(negedge clk) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (!acc_edge) begin
                checks++;
                if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
                    failures++;
                    $display("FAIL idle_cycle: win_valid=%0b frame_done=%0b, required 0 0",
                             win_valid, frame_done);
                end
            end else if (win_valid === 1'b1) begin
                n_win++;
                if (frame_done === 1'b1) n_done++;
                checks++;
                if (expq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_window: row=%0d col=%0d, required no window",
                             win_row, win_col);
                end else begin
                    e = expq.pop_front();
                    if (win_out !== e.win || win_row !== e.row || win_col !== e.col ||
                        frame_done !== e.done) begin
                        failures++;
                        $display("FAIL window: got row=%0d col=%0d done=%0b out=%h, required row=%0d col=%0d done=%0b out=%h",
                                 win_row, win_col, frame_done, win_out,
                                 e.row, e.col, e.done, e.win);
                    end
                end
            end else if (frame_done !== 1'b0) begin
                checks++;
                failures++;
                $display("FAIL lone_frame_done: frame_done=%0b without window, required 0",
                         frame_done);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
        chk_zero = 1'b0; chk_nowin = 1'b0; mr = 0; mc = 0;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        mon_en = 1'b1;

        send_frame(0, 0,   H, 0, 1'b0);
        send_frame(1, 0,   H, 0, 1'b0);
        send_frame(0, 100, H, 0, 1'b0);
        send_frame(0, 0,  10, 7, 1'b0);
        send_frame(2, 0,   H, 0, 1'b1);
        send_frame(0, 0,  20, 15, 1'b0);

        rst = 1'b1; start = 1'b0; pix_valid = 1'b1; pix_in = 8'hAA;
        mr = 0; mc = 0;
        @(posedge clk); #1;
        check_zero("in_reset_1");
        @(posedge clk); #1;
        check_zero("in_reset_2");
        chk_zero = 1'b1;
        send_frame(2, 0, H, 0, 1'b0);

        repeat (5) drive(8'h00, 1'b0, 1'b0);

        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL missing_windows: pending=%0d, required 0", expq.size());
        end
        checks++;
        if (n_win != 784*5 + 171 + 459) begin
            failures++;
            $display("FAIL window_count: got %0d, required %0d", n_win, 784*5 + 171 + 459);
        end
        checks++;
        if (n_done != 5) begin
            failures++;
            $display("FAIL frame_done_count: got %0d, required 5", n_done);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the 25-tap convolution PE.
- Converts a raster-order stream of unsigned 8-bit activations into a sliding 5x5 window, stride 1, no padding.
- Window is presented as 25 parallel bytes, ready to drive the PE's in_IF1..in_IF25 inputs directly.
- Uses four internal line buffers plus a 5x5 shift-register window; one window per accepted pixel once the window is fully inside the image.

Parameters:
- IMG_W, 32, image width in pixels (>= 5).
- IMG_H, 32, image height in pixels (>= 5).
- CW, 6, counter width; must satisfy 2^CW >= max(IMG_W, IMG_H).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; restarts frame position at (row 0, col 0).
- pix_valid  in  1  pix_in is valid this cycle and is consumed.
- pix_in  in  8  unsigned activation, raster order.
- win_valid  out  1  win_out holds a complete window this cycle.
- win_out  out  200  window; byte k = win_out[8k+7:8k], k = 5*r + c, r/c = 0..4.
  - r=0 is the oldest row, c=0 the oldest column.
  - Byte 0 maps to in_IF1; byte 24 maps to in_IF25.
- win_row  out  CW  image row of the window's top-left pixel.
- win_col  out  CW  image column of the window's top-left pixel.
- frame_done  out  1  pulses with the last window of a frame.

Behaviour:
- Reset (rst=1 at a clock edge), regardless of other inputs:
  - win_valid=0, frame_done=0, win_out=0, win_row=0, win_col=0.
  - Internal row/col counters cleared to 0.
  - Line-buffer contents need not be cleared; they are never exposed, see validity rule.
- Counters (row, col) give the position of the next pixel to be accepted.
- Accept occurs only when pix_valid=1; pix_valid=0 is a stall:
  - No counter, window or line-buffer change.
  - win_valid=0 and frame_done=0 on the following cycle.
- On accept:
  - pix_in is shifted into window row 4, column 4.
  - Column data of rows 0..3 is read from the line buffers at address col.
  - Line buffers shift: the buffer holding image row row-1 supplies window row 3, and so on upward; pix_in is written to the buffer for the current row.
  - Window columns shift left by one.
- Counter update on accept:
  - col increments.
  - At col=IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0.
- Window validity and outputs:
  - Registered outputs, latency 1: the cycle after accepting the pixel at (row, col) with row>=4 and col>=4, win_valid=1.
  - On that cycle, win_out byte(r,c) = pixel(row-4+r, col-4+c).
  - On that cycle, win_row=row-4 and win_col=col-4.
  - Otherwise win_valid=0; win_out, win_row and win_col hold their last values.
- Frame totals and frame_done:
  - Windows per frame = (IMG_H-4)*(IMG_W-4); 784 for the defaults.
  - frame_done=1 on the same cycle as the window for pixel (IMG_H-1, IMG_W-1); 0 otherwise.
- Horizontal wrap: row r's first 4 pixels never produce a window.
  - Window contents in columns from the previous row are overwritten before the next valid window, so no masking is needed.
- Back-to-back frames:
  - Rows 0..3 of a new frame produce no windows, even though line buffers hold old-frame data.
  - No idle cycles are required between frames.
- start:
  - start=1 clears counters to 0 in that cycle.
  - If pix_valid=1 in the same cycle, that pixel is accepted as (0,0).
  - Any window due on the next cycle from pre-start data is suppressed (win_valid=0).
  - Mid-frame start discards the partial frame; no frame_done is issued for it.
- Priority: rst > start > pix_valid.
- Throughput: one pixel per cycle sustained, no backpressure; the consumer must accept every window.
- Storage: 4 line buffers of IMG_W bytes each (register array or inferred RAM, read-before-write at the same address).

Test Plan:
- Ramp frame: pixel(r,c) = (32r+c) mod 256, continuous pix_valid.
  - First win_valid occurs 1 cycle after accepting (4,4), with win_row=0, win_col=0, byte0=0, byte4=4, byte20=128, byte24=132.
  - Exactly 784 windows are produced, raster-ordered by (win_row, win_col).
  - frame_done asserts only with window (27,27), whose byte24 = (31*32+31) mod 256 = 255.
- Stall: same frame with pix_valid pseudo-random at 50% duty.
  - Window sequence is identical to the continuous case.
  - No win_valid occurs on the cycle after a stall.
- Row boundary: compare windows (0,27) and (1,0).
  - No window is emitted for cols 28..31 of any row.
  - Window (1,0) byte0 = pixel(1,0) = 32.
- Back-to-back frames: second ramp frame offset +100 immediately follows the first.
  - No win_valid during the second frame's rows 0..3.
  - First window of frame 2 has byte0=100.
  - Exactly 784 windows and one frame_done per frame.
- Mid-frame start: pulse start together with pix_valid at pixel (10,7) of frame 1, then send a full frame.
  - No window on the cycle after start.
  - Frame 1 gets no frame_done.
  - The new frame yields 784 correct windows.
- Reset mid-frame: assert rst for 2 cycles at pixel (20,15), holding pix_valid=1.
  - All outputs read 0 during and 1 cycle after reset.
  - A subsequent full frame produces the correct 784 windows.
